// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: streams a length-prefixed vector of FP16 operands through
// one shared combinational FP16 adder and returns the left-folded sum with
// sticky NaN / infinity status. Also contains floadd, the IEEE-754 binary16
// adder (round-to-nearest-even, subnormals supported, canonical quiet NaN).

module floadd (
  input  logic        clk,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [15:0] result
);

  // Purely combinational; the clock pin exists only for drop-in compatibility.
  logic unused_clk;
  assign unused_clk = clk;

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, eff_sub, rnd_up;
  logic [15:0] x, y;
  logic [5:0]  ex, ey, diff, e;
  logic [4:0]  dsh;
  logic [13:0] mx, my, my_al, m;
  logic [27:0] sh;
  logic [14:0] sum;
  logic [11:0] rnd;
  logic [4:0]  exp_f;
  logic [9:0]  frac_f;

  // Align, add/subtract, normalise and round the two operands.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned (which would infer a latch); blocking '=' is correct here
    // because this is combinational logic evaluated top to bottom.
    result = 16'h0000;
    exp_f  = 5'd0;
    frac_f = 10'd0;

    a_nan = (num1[14:10] == 5'h1f) && (num1[9:0] != 10'd0);
    b_nan = (num2[14:10] == 5'h1f) && (num2[9:0] != 10'd0);
    a_inf = (num1[14:10] == 5'h1f) && (num1[9:0] == 10'd0);
    b_inf = (num2[14:10] == 5'h1f) && (num2[9:0] == 10'd0);

    // Larger magnitude goes to x so the aligned difference is never negative.
    swap = num2[14:0] > num1[14:0];
    x    = swap ? num2 : num1;
    y    = swap ? num1 : num2;

    // Subnormals share the exponent of the smallest normal, without hidden bit.
    ex = {1'b0, (x[14:10] == 5'd0) ? 5'd1 : x[14:10]};
    ey = {1'b0, (y[14:10] == 5'd0) ? 5'd1 : y[14:10]};
    mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
    my = {(y[14:10] != 5'd0), y[9:0], 3'b000};

    // Right-shift the smaller operand, folding lost bits into a sticky LSB.
    diff  = ex - ey;
    dsh   = (diff > 6'd15) ? 5'd15 : diff[4:0];
    sh    = {my, 14'd0} >> dsh;
    my_al = sh[27:14] | {13'd0, |sh[13:0]};

    eff_sub = x[15] ^ y[15];
    sum     = eff_sub ? ({1'b0, mx} - {1'b0, my_al})
                      : ({1'b0, mx} + {1'b0, my_al});

    // Carry out shifts right once; otherwise shift left until normal or
    // until the exponent reaches the subnormal floor.
    e = ex;
    if (sum[14]) begin
      m = sum[14:1] | {13'd0, sum[0]};
      e = ex + 6'd1;
    end else begin
      m = sum[13:0];
    end
    for (int i = 0; i < 14; i++) begin
      if (!m[13] && (e > 6'd1)) begin
        m = m << 1;
        e = e - 6'd1;
      end
    end

    // Round to nearest, ties to even.
    rnd_up = m[2] & (m[1] | m[0] | m[3]);
    rnd    = {1'b0, m[13:3]} + {11'd0, rnd_up};
    if (rnd[11]) begin
      e      = e + 6'd1;
      exp_f  = e[4:0];
      frac_f = 10'd0;
    end else if (rnd[10]) begin
      exp_f  = e[4:0];
      frac_f = rnd[9:0];
    end else begin
      exp_f  = 5'd0;
      frac_f = rnd[9:0];
    end

    if (sum == 15'd0) begin
      // Exact cancellation yields +0; adding two zeros keeps their sign.
      result = {(~eff_sub) & x[15], 15'd0};
    end else if (e >= 6'd31) begin
      result = {x[15], 5'h1f, 10'd0};
    end else begin
      result = {x[15], exp_f, frac_f};
    end

    // Special operands override the arithmetic path.
    if (a_nan || b_nan || (a_inf && b_inf && (num1[15] != num2[15]))) begin
      result = 16'h7e00;
    end else if (a_inf) begin
      result = num1;
    end else if (b_inf) begin
      result = num2;
    end
  end

endmodule

module fp16_accum_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_nan,
  output logic             out_inf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [15:0]      acc_q, acc_d;
  logic             nan_q, nan_d;
  logic             inf_q, inf_d;
  logic [15:0]      add_sum;
  logic             in_is_nan, sum_is_inf;

  floadd u_add (
    .clk    (clk),
    .num1   (acc_q),
    .num2   (in_data),
    .result (add_sum)
  );

  assign in_is_nan  = (in_data[14:10] == 5'h1f) && (in_data[9:0] != 10'd0);
  assign sum_is_inf = (add_sum[14:0] == 15'h7c00);

  assign out_data = acc_q;
  assign out_nan  = nan_q;
  assign out_inf  = inf_q;
  assign busy     = (state_q != IDLE);

  // State, counter, accumulator and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: asynchronous reset in the sensitivity list clears state the moment
    // rst_n falls; sequential state uses non-blocking '<=' only.
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_q       <= 16'h0000;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    nan_d       = nan_q;
    inf_d       = inf_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = len;
          acc_d       = 16'h0000;
          nan_d       = 1'b0;
          inf_d       = 1'b0;
          state_d     = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d       = add_sum;
          remaining_d = remaining_q - 1'b1;
          nan_d       = nan_q | in_is_nan;
          inf_d       = inf_q | sum_is_inf;
          if (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Directed testbench for fp16_accum_seq: hand-computed FP16 sums, handshake
// timing, stalls, special values and asynchronous reset.

module tb_fp16_accum_seq;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = 16'h0000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic             out_nan;
  logic             out_inf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_accum_seq #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nan   (out_nan),
    .out_inf   (out_inf),
    .busy      (busy)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, out_valid, out_nan, out_inf, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {in_ready, out_valid, out_nan, out_inf, busy}, 5'b00000);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", out_data, 16'h0000);
    end
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3c00;
    repeat (3) step();
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ignore_ctrl: got %b expected %b", {in_ready, busy, out_valid}, 3'b000);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("FAIL idle_ignore_acc: got %h expected %h", out_data, 16'h0000);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_start(8'd3);
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL basic_start: got %b expected %b", {in_ready, busy}, 2'b11);
    end
    feed(16'h3c00);
    feed(16'h3800);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_early: got %b expected %b", {out_valid, in_ready}, 2'b01);
    end
    feed(16'h3400);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL basic_latency: got %b expected %b", {out_valid, in_ready}, 2'b10);
    end
    checks++;
    if (out_data !== 16'h3f00) begin
      errors++;
      $display("FAIL basic_sum: got %h expected %h", out_data, 16'h3f00);
    end
    checks++;
    if ({out_nan, out_inf} !== 2'b00) begin
      errors++;
      $display("FAIL basic_flags: got %b expected %b", {out_nan, out_inf}, 2'b00);
    end
    take();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_release: got %b expected %b", {out_valid, busy}, 2'b00);
    end
  endtask

  task automatic test_cancel_zero();
    do_start(8'd0);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL zero_len_ctrl: got %b expected %b", {out_valid, in_ready}, 2'b10);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("FAIL zero_len_data: got %h expected %h", out_data, 16'h0000);
    end
    take();
    do_start(8'd2);
    feed(16'h3c00);
    feed(16'hbc00);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL cancel: got valid=%b data=%h expected valid=1 data=0000", out_valid, out_data);
    end
    take();
  endtask

  task automatic test_stalls();
    do_start(8'd2);
    repeat (3) step();
    feed(16'h3c00);
    repeat (3) step();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_hold: got %b expected %b", {in_ready, out_valid}, 2'b10);
    end
    feed(16'h3800);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3e00) begin
      errors++;
      $display("FAIL stall_sum: got valid=%b data=%h expected valid=1 data=3e00", out_valid, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h3e00) begin
        errors++;
        $display("FAIL consumer_stall_%0d: got valid=%b data=%h expected valid=1 data=3e00",
                 i, out_valid, out_data);
      end
    end
    // start coinciding with the result handshake is ignored
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL start_in_done: got %b expected %b", {busy, in_ready, out_valid}, 3'b000);
    end
    // start during ACC is ignored
    do_start(8'd2);
    feed(16'h3c00);
    start = 1'b1;
    len   = 8'd5;
    step();
    start = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL start_in_acc: got %b expected %b", {in_ready, out_valid}, 2'b10);
    end
    feed(16'h3800);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3e00) begin
      errors++;
      $display("FAIL start_in_acc_sum: got valid=%b data=%h expected valid=1 data=3e00",
               out_valid, out_data);
    end
    take();
  endtask

  task automatic test_special();
    logic is_nan;
    do_start(8'd2);
    feed(16'h7e00);
    feed(16'h3c00);
    is_nan = (out_data[14:10] == 5'h1f) && (out_data[9:0] != 10'd0);
    checks++;
    if ({out_valid, is_nan, out_nan, out_inf} !== 4'b1110) begin
      errors++;
      $display("FAIL nan_sum: got valid/isnan/nan/inf=%b expected %b data=%h",
               {out_valid, is_nan, out_nan, out_inf}, 4'b1110, out_data);
    end
    take();
    do_start(8'd1);
    feed(16'h7c00);
    checks++;
    if (out_data !== 16'h7c00) begin
      errors++;
      $display("FAIL inf_data: got %h expected %h", out_data, 16'h7c00);
    end
    checks++;
    if ({out_nan, out_inf} !== 2'b01) begin
      errors++;
      $display("FAIL inf_flags: got %b expected %b", {out_nan, out_inf}, 2'b01);
    end
    take();
    do_start(8'd1);
    checks++;
    if ({out_nan, out_inf} !== 2'b00) begin
      errors++;
      $display("FAIL flags_clear: got %b expected %b", {out_nan, out_inf}, 2'b00);
    end
    feed(16'h3c00);
    checks++;
    if (out_data !== 16'h3c00 || {out_nan, out_inf} !== 2'b00) begin
      errors++;
      $display("FAIL after_special: got data=%h flags=%b expected data=3c00 flags=00",
               out_data, {out_nan, out_inf});
    end
    take();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(8'd5);
    feed(16'h3c00);
    feed(16'h3c00);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, out_nan, out_inf} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %b expected %b",
               {busy, in_ready, out_valid, out_nan, out_inf}, 5'b00000);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_data: got %h expected %h", out_data, 16'h0000);
    end
    #3;
    rst_n = 1'b1;
    step();
    do_start(8'd1);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    step();
    in_valid = 1'b0;
    wait_valid(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_timeout: got out_valid=%b expected 1", out_valid);
    end
    checks++;
    if (out_data !== 16'h4000) begin
      errors++;
      $display("FAIL post_reset_sum: got %h expected %h", out_data, 16'h4000);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel_zero();
    test_stalls();
    test_special();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_accum_seq.md
# fp16_accum_seq

Sequencing controller that streams a length-prefixed vector of FP16 operands through one shared combinational FP16 adder (`floadd`) and produces the running sum as a single result. It owns the accumulator register, beat counter and valid/ready handshakes on both sides, and reports NaN and infinity status alongside the result. It sits between an operand buffer (input stream) and the layer-output writer, and is the reduction stage for bias and partial-sum accumulation.

## Interface
- `LEN_W`, default 8: width of the vector-length field; supports vectors of up to 2^LEN_W−1 elements.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  pulse requesting a new reduction; sampled only in IDLE.
- `len`  in  LEN_W  element count for the reduction; sampled with `start`.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  controller accepts an operand this cycle.
- `in_data`  in  16  FP16 operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  16  FP16 accumulated sum.
- `out_nan`  out  1  sticky flag: at least one accepted operand was NaN (exp=11111, frac≠0).
- `out_inf`  out  1  sticky flag: at least one adder result was ±infinity (exp=11111, frac=0).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start`=1: load `remaining`←`len`, `acc`←16'h0000, and clear `out_nan` and `out_inf`.
  - If `len`==0, go to DONE. Otherwise go to ACC.
- ACC:
  - `in_ready`=1.
  - On accept (`in_valid`&&`in_ready`):
    - `acc`←floadd(num1=`acc`, num2=`in_data`). The operand order is fixed.
    - `remaining`←`remaining`−1.
    - `out_nan` |= `in_data` is NaN.
    - `out_inf` |= the adder result is ±inf.
  - An accept with `remaining`==1 transitions to DONE.
- DONE:
  - `out_valid`=1 and `out_data`=`acc`. Both are held stable until `out_ready`.
  - On `out_ready`=1, go to IDLE.
- `start` is ignored in ACC and DONE. If `start` arrives in the same cycle that DONE completes, it is ignored and must be reissued in IDLE.
- `in_valid` outside ACC is ignored: no accept and no state change.
- Arithmetic:
  - The result is exactly the left-fold of the adder over the accepted operands, starting from +0.
  - No rounding or renormalisation beyond what the adder itself does.
  - The adder's `clk` port is tied to `clk`.
- `out_data` is driven from the `acc` register, never combinationally from the adder.
- `remaining` is LEN_W bits wide and never wraps. `len`==0 is the only zero-length case.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=16'h0000, `out_nan`=0, `out_inf`=0, `busy`=0. State is IDLE and `acc`=0.
- Assertion of `rst_n` low takes effect immediately, including mid-ACC or mid-DONE. Any partial sum is discarded.
- `start` sampled at edge T → `in_ready`=1 and `busy`=1 from T+1.
- For `len`==0: `out_valid`=1 from T+1.
- Throughput is one operand per cycle while `in_valid` is held high.
- Last accept at edge T → `in_ready`=0 and `out_valid`=1 from T+1.
- `len`=N with no stalls: `out_valid` rises N+1 cycles after the `start` edge.
- Result handshake at edge T → `out_valid`=0 and `busy`=0 from T+1. The earliest next `start` is sampled at T+1.
- Source stalls (`in_valid`=0) in ACC simply hold all state.
- Consumer stalls (`out_ready`=0) in DONE hold `out_data` and the flags.

## Test plan
- **Reset and idle:** assert `rst_n`=0, then release. Expect all outputs 0. Drive `in_valid`=1 in IDLE with no `start`: expect `in_ready`=0 and `acc` unchanged.
- **Basic sum:** `start`, `len`=3, operands 0x3C00, 0x3800, 0x3400 back-to-back. Expect `out_valid` 4 cycles after `start`, `out_data`=0x3F00 (1.75), flags 0.
- **Cancellation and zero length:**
  - `len`=2, operands 0x3C00, 0xBC00: expect `out_data`=0x0000.
  - `len`=0: expect `out_valid` the cycle after `start` with `out_data`=0x0000.
- **Stalls:**
  - `len`=2 with `in_valid` gaps of 3 cycles: expect the same 0x3E00 result as operands 0x3C00, 0x3800 unstalled.
  - Hold `out_ready`=0 for 5 cycles: expect `out_data`/`out_valid` stable.
  - `start` pulsed during ACC is ignored.
- **Special values:**
  - `len`=2, operands 0x7E00, 0x3C00: expect `out_nan`=1.
  - `len`=1, operand 0x7C00: expect `out_data`=0x7C00 and `out_inf`=1.
  - The next reduction clears both flags.
- **Reset mid-operation:** after 2 of `len`=5 beats, pulse `rst_n` low asynchronously. Expect immediate return to reset values. A new `len`=1 reduction of 0x4000 then returns 0x4000.
